// File: rtl/wb_ksa_regs.sv
// wb_ksa_regs: Wishbone register front-end for a pipelined Kogge-Stone adder.
// Firmware loads OPA/OPB and pulses START. The sum appears in RESULT L+2
// cycles later, where L = log2(WIDTH). Completion sets DONE and can raise irq[0].
module wb_ksa_regs #(
  parameter int          WIDTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [2:0]       irq,
  output logic [WIDTH:0]   result_o
);

  localparam int L      = $clog2(WIDTH);
  localparam int STAGES = L + 1;           // stage 0, L prefix levels, sum stage

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_OPA    = 3'd1;
  localparam logic [2:0] OFF_OPB    = 3'd2;
  localparam logic [2:0] OFF_RESULT = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic             ack_q,    ack_d;
  logic [31:0]      dat_o_q,  dat_o_d;
  logic [WIDTH-1:0] opa_q,    opa_d;
  logic [WIDTH-1:0] opb_q,    opb_d;
  logic             irq_en_q, irq_en_d;
  logic             acc_q,    acc_d;
  logic             done_q,   done_d;
  logic             busy_q,   busy_d;
  logic             err_q,    err_d;
  logic [WIDTH:0]   result_q, result_d;

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  // g/p per prefix level; the level-L propagate is never consumed, so it is not kept
  logic [L:0][WIDTH-1:0]   g_q,  g_d;
  logic [L-1:0][WIDTH-1:0] p_q,  p_d;
  logic [L:0][WIDTH-1:0]   p0_q, p0_d;     // stage-0 propagate, carried along for the sum
  logic [WIDTH:0]          fin_q, fin_d;   // {cout, sum}
  logic [STAGES:0]         vld_pipe;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic        hit, access, wr, rd;
  logic [2:0]  off;
  logic [31:0] wmask;
  logic [WIDTH-1:0] opa_wr, opb_wr;
  logic        start_req, start_go, err_set, done_evt;
  logic [31:0] rdata;

  // The block claims a 32-byte window. Words past STATUS ack and read 0.
  assign hit    = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign off    = wbs_adr_i[4:2];
  assign access = wbs_stb_i & wbs_cyc_i & ~ack_q & hit;
  assign wr     = access & wbs_we_i;
  assign rd     = access & ~wbs_we_i;

  assign wmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                   {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign opa_wr = (opa_q & ~wmask[WIDTH-1:0]) | (wbs_dat_i[WIDTH-1:0] & wmask[WIDTH-1:0]);
  assign opb_wr = (opb_q & ~wmask[WIDTH-1:0]) | (wbs_dat_i[WIDTH-1:0] & wmask[WIDTH-1:0]);

  assign start_req = wr & (off == OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[0];
  assign start_go  = start_req & ~busy_q;
  assign err_set   = start_req &  busy_q;
  assign done_evt  = vld_pipe[STAGES];

  // ---------------------------------------------------------------------------
  // Kogge-Stone datapath
  // ---------------------------------------------------------------------------
  // Stage 0 holds its value between starts. Later stages flow every cycle, and vld_pipe qualifies them.
  assign g_d[0]  = start_go ? (opa_q & opb_q) : g_q[0];
  assign p_d[0]  = start_go ? (opa_q ^ opb_q) : p_q[0];
  assign p0_d[0] = start_go ? (opa_q ^ opb_q) : p0_q[0];

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int D = 2 ** (k - 1);
    assign g_d[k][D-1:0]     = g_q[k-1][D-1:0];
    assign g_d[k][WIDTH-1:D] = g_q[k-1][WIDTH-1:D]
                             | (p_q[k-1][WIDTH-1:D] & g_q[k-1][WIDTH-1-D:0]);
    assign p0_d[k]           = p0_q[k-1];
    if (k < L) begin : g_p
      assign p_d[k][D-1:0]     = p_q[k-1][D-1:0];
      assign p_d[k][WIDTH-1:D] = p_q[k-1][WIDTH-1:D] & p_q[k-1][WIDTH-1-D:0];
    end
  end

  // With carry-in 0, the level-L group generate at bit i is the carry into bit i+1
  assign fin_d = {g_q[L][WIDTH-1], p0_q[L] ^ {g_q[L][WIDTH-2:0], 1'b0}};

  // Pipeline registers; the valid bit shifts alongside the data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      g_q      <= '0;
      p_q      <= '0;
      p0_q     <= '0;
      fin_q    <= '0;
      vld_pipe <= '0;
    end else begin
      g_q      <= g_d;
      p_q      <= p_d;
      p0_q     <= p0_d;
      fin_q    <= fin_d;
      vld_pipe <= {vld_pipe[STAGES-1:0], start_go};
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  // Read mux; values are sampled before this edge's write
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:   rdata[2:1]       = {acc_q, irq_en_q};
      OFF_OPA:    rdata[WIDTH-1:0] = opa_q;
      OFF_OPB:    rdata[WIDTH-1:0] = opb_q;
      OFF_RESULT: rdata[WIDTH:0]   = result_q;
      OFF_STATUS: rdata[2:0]       = {err_q, busy_q, done_q};
      default:    rdata            = '0;
    endcase
  end

  // Next-state for registers: firmware writes first, completion overrides them
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    irq_en_d = irq_en_q;
    acc_d    = acc_q;
    done_d   = done_q;
    busy_d   = busy_q;
    err_d    = err_q;
    result_d = result_q;
    if (wr) begin
      case (off)
        OFF_CTRL: if (wbs_sel_i[0]) begin
          irq_en_d = wbs_dat_i[1];
          acc_d    = wbs_dat_i[2];
        end
        OFF_OPA: opa_d = opa_wr;
        OFF_OPB: opb_d = opb_wr;
        OFF_STATUS: if (wbs_sel_i[0]) begin
          if (wbs_dat_i[0]) done_d = 1'b0;
          if (wbs_dat_i[2]) err_d  = 1'b0;
        end
        default: ;
      endcase
    end
    if (start_go) busy_d = 1'b1;
    if (err_set)  err_d  = 1'b1;
    if (done_evt) begin
      result_d = fin_q;
      done_d   = 1'b1;
      busy_d   = 1'b0;
      if (acc_q) opa_d = fin_q[WIDTH-1:0];
    end
  end

  // Single-cycle ack with registered read data
  always_comb begin
    ack_d   = access;
    dat_o_d = rd ? rdata : '0;
  end

  // Register-file and bus-response state
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_o_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      irq_en_q <= 1'b0;
      acc_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_o_q  <= dat_o_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      irq_en_q <= irq_en_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_o_q;
  assign irq       = {2'b00, done_q & irq_en_q};
  assign result_o  = result_q;

  // Address bits below word granularity and upper data/mask bits are intentionally ignored
  logic unused_ok;
  assign unused_ok = &{1'b0, wbs_adr_i, wbs_dat_i, wmask};

endmodule

// File: tb/tb_wb_ksa_regs.sv
// tb_wb_ksa_regs: directed and random register traffic against a behavioural
// model. The model treats in-flight adds as a queue of (due cycle, sum) entries.
module tb_wb_ksa_regs;
  localparam int          W    = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat = '0, adr = '0;
  wire         ack;
  wire  [31:0] dato;
  wire  [2:0]  irq;
  wire  [W:0]  res;

  wb_ksa_regs #(.WIDTH(W), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dato), .irq(irq), .result_o(res)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0, cycn = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cycn);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [W:0] s; } pend_t;
  pend_t       pend[$];
  logic [W-1:0] m_opa, m_opb;
  logic        m_ien, m_acc, m_done, m_busy, m_err, m_ack, m_rd;
  logic [W:0]  m_res;
  logic [31:0] m_rdata;

  task automatic model_edge();
    logic [31:0] mk, rdv;
    logic        hitm, acs, acc_old;
    logic [2:0]  o;
    pend_t       p;
    if (rst) begin
      m_opa = '0; m_opb = '0; m_ien = 0; m_acc = 0; m_done = 0; m_busy = 0;
      m_err = 0; m_res = '0; m_ack = 0; m_rd = 0; m_rdata = '0;
      pend.delete();
      return;
    end
    hitm    = (adr[31:5] == BASE[31:5]);
    o       = adr[4:2];
    acs     = stb && cyc && !m_ack && hitm;
    mk      = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    acc_old = m_acc;
    case (o)
      3'd0:    rdv = {29'b0, m_acc, m_ien, 1'b0};
      3'd1:    rdv = {16'b0, m_opa};
      3'd2:    rdv = {16'b0, m_opb};
      3'd3:    rdv = {15'b0, m_res};
      3'd4:    rdv = {29'b0, m_err, m_busy, m_done};
      default: rdv = '0;
    endcase
    if (acs && we) begin
      case (o)
        3'd0: if (sel[0]) begin
          m_ien = dat[1];
          m_acc = dat[2];
          if (dat[0]) begin
            if (m_busy) m_err = 1'b1;
            else begin
              p.due = cycn + 6;
              p.s   = 17'(m_opa) + 17'(m_opb);
              pend.push_back(p);
              m_busy = 1'b1;
            end
          end
        end
        3'd1: m_opa = (m_opa & ~mk[15:0]) | (dat[15:0] & mk[15:0]);
        3'd2: m_opb = (m_opb & ~mk[15:0]) | (dat[15:0] & mk[15:0]);
        3'd4: if (sel[0]) begin
          if (dat[0]) m_done = 1'b0;
          if (dat[2]) m_err  = 1'b0;
        end
        default: ;
      endcase
    end
    if (pend.size() > 0 && pend[0].due == cycn) begin
      p = pend.pop_front();
      m_res  = p.s;
      m_done = 1'b1;
      m_busy = 1'b0;
      if (acc_old) m_opa = p.s[W-1:0];
    end
    m_ack   = acs;
    m_rd    = acs && !we;
    m_rdata = rdv;
  endtask

  // One clock: advance the model, then compare visible outputs
  task automatic tick();
    @(posedge clk);
    cycn++;
    model_edge();
    #1;
    chk("ack",      {31'b0, ack},          {31'b0, m_ack});
    chk("irq",      {29'b0, irq},          {29'b0, 2'b00, m_done & m_ien});
    chk("result_o", 32'(res),              32'(m_res));
    if (m_ack && m_rd) chk("rdata", dato, m_rdata);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Single wishbone access, bounded to 3 cycles waiting for ack
  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rv, output bit got);
    got = 1'b0; rv = '0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    for (int n = 0; n < 3 && !got; n++) begin
      tick();
      if (ack) begin got = 1'b1; rv = dato; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] o, input logic [31:0] d);
    logic [31:0] rv; bit got;
    bus(1'b1, BASE + 32'(o), d, 4'hF, rv, got);
    chk("wr_ack", {31'b0, got}, 32'd1);
  endtask

  task automatic rd_reg(input logic [7:0] o, output logic [31:0] v);
    bit got;
    bus(1'b0, BASE + 32'(o), 32'h0, 4'hF, v, got);
    chk("rd_ack", {31'b0, got}, 32'd1);
  endtask

  logic [31:0] v, a, d;
  logic [3:0]  s;
  bit          got;
  logic [W:0]  acc_exp [3];

  initial begin
    acc_exp[0] = 17'h0_8000; acc_exp[1] = 17'h1_0000; acc_exp[2] = 17'h0_8000;

    // reset
    rst = 1'b1;
    idle(3);
    chk("rst_result", 32'(res), 32'h0);
    chk("rst_ack",    {31'b0, ack}, 32'h0);
    chk("rst_irq",    {29'b0, irq}, 32'h0);
    chk("rst_dat",    dato, 32'h0);
    rst = 1'b0;
    idle(1);

    // basic add, exact latency
    wr_reg(8'h04, 32'h1234);
    wr_reg(8'h08, 32'h4321);
    wr_reg(8'h00, 32'h1);
    idle(5);
    chk("add_early", 32'(res), 32'h0);
    idle(1);
    chk("add_sum", 32'(res), 32'h0_5555);
    rd_reg(8'h0C, v); chk("add_rd_result", v, 32'h0_5555);
    rd_reg(8'h10, v); chk("add_status", v, 32'h1);
    wr_reg(8'h10, 32'h1);

    // carry out and irq timing
    wr_reg(8'h00, 32'h2);
    wr_reg(8'h04, 32'hFFFF);
    wr_reg(8'h08, 32'h0001);
    wr_reg(8'h00, 32'h3);
    idle(5);
    chk("cy_irq_early", {29'b0, irq}, 32'h0);
    idle(1);
    chk("cy_irq",    {29'b0, irq}, 32'h1);
    chk("cy_result", 32'(res), 32'h1_0000);
    wr_reg(8'h10, 32'h1);
    chk("cy_irq_clr", {29'b0, irq}, 32'h0);

    // accumulate mode
    wr_reg(8'h00, 32'h4);
    wr_reg(8'h04, 32'h0);
    wr_reg(8'h08, 32'h8000);
    for (int i = 0; i < 3; i++) begin
      wr_reg(8'h00, 32'h5);
      idle(7);
      chk("acc_result", 32'(res), 32'(acc_exp[i]));
    end
    rd_reg(8'h04, v); chk("acc_opa", v, 32'h8000);
    wr_reg(8'h00, 32'h0);
    wr_reg(8'h10, 32'h5);

    // busy rejection
    wr_reg(8'h04, 32'h1111);
    wr_reg(8'h08, 32'h0001);
    wr_reg(8'h00, 32'h1);
    wr_reg(8'h08, 32'h0100);
    wr_reg(8'h00, 32'h1);
    rd_reg(8'h10, v); chk("busy_status", v, 32'h6);
    idle(6);
    chk("busy_result", 32'(res), 32'h0_1112);
    rd_reg(8'h10, v); chk("busy_err", v, 32'h5);
    wr_reg(8'h10, 32'h4);
    rd_reg(8'h10, v); chk("err_clr", v, 32'h1);
    rd_reg(8'h08, v); chk("opb_new", v, 32'h0100);
    wr_reg(8'h10, 32'h1);

    // byte lanes and decode
    wr_reg(8'h04, 32'h0);
    bus(1'b1, BASE + 32'h4, 32'hAABB, 4'b0001, v, got);
    chk("lane_ack", {31'b0, got}, 32'd1);
    rd_reg(8'h04, v); chk("lane_opa", v, 32'h00BB);
    rd_reg(8'h14, v); chk("unmapped_rd", v, 32'h0);
    bus(1'b0, BASE + 32'h100, 32'h0, 4'hF, v, got);
    chk("outside_noack", {31'b0, got}, 32'd0);

    // reset mid-operation
    wr_reg(8'h00, 32'h2);
    wr_reg(8'h04, 32'h5);
    wr_reg(8'h08, 32'h7);
    wr_reg(8'h00, 32'h3);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rstop_result", 32'(res), 32'h0);
    end
    rd_reg(8'h10, v); chk("rstop_status", v, 32'h0);
    wr_reg(8'h04, 32'h5);
    wr_reg(8'h08, 32'h7);
    wr_reg(8'h00, 32'h1);
    idle(6);
    chk("rstop_restart", 32'(res), 32'h0_000C);

    // random traffic against the model
    for (int it = 0; it < 600; it++) begin
      a = BASE + {27'b0, 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 15) == 0) a = a ^ 32'h0000_0100;
      d = $urandom;
      s = 4'($urandom);
      if ($urandom_range(0, 9) < 6) bus(1'b1, a, d, s, v, got);
      else                          bus(1'b0, a, d, s, v, got);
      idle($urandom_range(0, 3));
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
